// File: rtl/fp_mult_pkg.sv
// Shared constants and types for the pipelined IEEE-754 multiplier.
// Holds rounding-mode codes, flag bit positions, the operand class and the canonical NaN.
package fp_mult_pkg;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RTZ = 2'd1;
    localparam logic [1:0] RM_RUP = 2'd2;
    localparam logic [1:0] RM_RDN = 2'd3;

    localparam int FLG_NV = 4;
    localparam int FLG_DZ = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    // Returned wide; callers truncate to their word width.
    function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Third-stage datapath: normalise the significand product, round, and pack
// the word, folding in FTZ underflow and mode-dependent overflow saturation.
module fp_mult_round
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                          sign,
    input  logic signed [EXP_W+1:0]       exp_in,
    input  logic [2*(MAN_W+1)-1:0]        prod,
    input  logic [1:0]                    rm,
    output logic [EXP_W+MAN_W:0]          result,
    output logic [4:0]                    flags
);

    localparam int PW = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_INF  = EW'((1 << EXP_W) - 1);

    logic [PW-1:0]          norm;
    logic signed [EW-1:0]   e_n;
    logic signed [EW-1:0]   e_r;
    logic [MAN_W-1:0]       frac;
    logic [MAN_W:0]         mant_r;
    logic                   g, r, s, inexact, inc, inf_sel;

    always_comb begin
        // Leading one always ends up at PW-1 so the field slices below are fixed.
        norm    = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
        e_n     = exp_in + {{(EW-1){1'b0}}, prod[PW-1]};
        frac    = norm[PW-2 -: MAN_W];
        g       = norm[MAN_W];
        r       = norm[MAN_W-1];
        s       = |norm[MAN_W-2:0];
        inexact = g | r | s;

        case (rm)
            RM_RNE:  inc = g & (r | s | frac[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = inexact & ~sign;
            default: inc = inexact & sign;
        endcase

        mant_r  = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
        e_r     = e_n + {{(EW-1){1'b0}}, mant_r[MAN_W]};
        inf_sel = (rm == RM_RNE) | ((rm == RM_RUP) & ~sign) | ((rm == RM_RDN) & sign);

        result         = {sign, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        flags          = '0;
        flags[FLG_NX]  = inexact;

        if (e_n <= EXP_ZERO) begin
            result         = {sign, {(EXP_W+MAN_W){1'b0}}};
            flags[FLG_UF]  = 1'b1;
            flags[FLG_NX]  = 1'b1;
        end else if (e_r >= EXP_INF) begin
            flags[FLG_OF]  = 1'b1;
            flags[FLG_NX]  = 1'b1;
            if (inf_sel)
                result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                result = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with tag passthrough and
// valid/ready flow control driven by one global advance enable.
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+MAN_W:0]      op_a,
    input  logic [EXP_W+MAN_W:0]      op_b,
    input  logic [1:0]                rm,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MAN_W:0]      result,
    output logic [4:0]                flags,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_E    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0]         CANON_NAN = W'(canon_nan(EXP_W, MAN_W));

    // Handshake: a pair is taken on a rising edge with in_valid & in_ready; a result
    // leaves with out_valid & out_ready. Every stage shifts together only when
    // adv = !out_valid | out_ready, so in_ready is adv and bubbles are never squeezed out.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        fp_class_e c;
        if (e == '0)            c = CLS_ZERO;
        else if (e != '1)       c = CLS_NORM;
        else if (f == '0)       c = CLS_INF;
        else if (f[MAN_W-1])    c = CLS_QNAN;
        else                    c = CLS_SNAN;
        return c;
    endfunction

    fp_class_e          cls_a, cls_b;
    logic               sign_d, special_d, nan_a, nan_b;
    logic [W-1:0]       special_res_d;
    logic [4:0]         special_flags_d;
    logic signed [EW-1:0] exp_sum_d;

    always_comb begin
        cls_a     = classify(op_a[W-2 -: EXP_W], op_a[MAN_W-1:0]);
        cls_b     = classify(op_b[W-2 -: EXP_W], op_b[MAN_W-1:0]);
        sign_d    = op_a[W-1] ^ op_b[W-1];
        exp_sum_d = $signed({2'b00, op_a[W-2 -: EXP_W]}) + $signed({2'b00, op_b[W-2 -: EXP_W]}) - BIAS_E;
        nan_a     = (cls_a == CLS_QNAN) | (cls_a == CLS_SNAN);
        nan_b     = (cls_b == CLS_QNAN) | (cls_b == CLS_SNAN);

        special_d       = 1'b1;
        special_res_d   = '0;
        special_flags_d = '0;
        if (nan_a | nan_b) begin
            special_res_d           = CANON_NAN;
            special_flags_d[FLG_NV] = (cls_a == CLS_SNAN) | (cls_b == CLS_SNAN);
        end else if (((cls_a == CLS_INF) & (cls_b == CLS_ZERO)) | ((cls_a == CLS_ZERO) & (cls_b == CLS_INF))) begin
            special_res_d           = CANON_NAN;
            special_flags_d[FLG_NV] = 1'b1;
        end else if ((cls_a == CLS_INF) | (cls_b == CLS_INF)) begin
            special_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((cls_a == CLS_ZERO) | (cls_b == CLS_ZERO)) begin
            special_res_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            special_d = 1'b0;
        end
    end

    logic                 s1_valid, s1_sign, s1_special;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_man_a, s1_man_b;
    logic [W-1:0]         s1_special_res;
    logic [4:0]           s1_special_flags;
    logic [1:0]           s1_rm;
    logic [TAG_W-1:0]     s1_tag;

    logic                 s2_valid, s2_sign, s2_special;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    logic [W-1:0]         s2_special_res;
    logic [4:0]           s2_special_flags;
    logic [1:0]           s2_rm;
    logic [TAG_W-1:0]     s2_tag;

    logic [W-1:0]         round_res;
    logic [4:0]           round_flags;

    fp_mult_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign   (s2_sign),
        .exp_in (s2_exp),
        .prod   (s2_prod),
        .rm     (s2_rm),
        .result (round_res),
        .flags  (round_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid         <= in_valid;
            s1_sign          <= sign_d;
            s1_exp           <= exp_sum_d;
            s1_man_a         <= {1'b1, op_a[MAN_W-1:0]};
            s1_man_b         <= {1'b1, op_b[MAN_W-1:0]};
            s1_special       <= special_d;
            s1_special_res   <= special_res_d;
            s1_special_flags <= special_flags_d;
            s1_rm            <= rm;
            s1_tag           <= in_tag;

            s2_valid         <= s1_valid;
            s2_sign          <= s1_sign;
            s2_exp           <= s1_exp;
            s2_prod          <= PW'(s1_man_a) * PW'(s1_man_b);
            s2_special       <= s1_special;
            s2_special_res   <= s1_special_res;
            s2_special_flags <= s1_special_flags;
            s2_rm            <= s1_rm;
            s2_tag           <= s1_tag;

            out_valid        <= s2_valid;
            result           <= s2_special ? s2_special_res : round_res;
            flags            <= s2_special ? s2_special_flags : round_flags;
            out_tag          <= s2_tag;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (FP32): directed corner vectors plus a
// randomized stream, checked through a scoreboard fed by an arithmetic reference model.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [1:0]  rm = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  flags;
    logic [3:0]  out_tag;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .rm        (rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [3:0]  tag;
    } op_t;

    op_t         drv_q[$];
    logic [40:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_pop   = 0;
    int cyc     = 0;
    int in_cyc  = 0;
    int out_cyc = 0;
    logic last_in_ready;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
    function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
        int ea, eb, e, sh;
        longint unsigned p, q, rem, half;
        logic sign, nan_a, nan_b, snan, inf_a, inf_b, zero_a, zero_b, inexact, up, to_inf;
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        sign   = a[31] ^ b[31];
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        snan   = (nan_a && !a[22]) || (nan_b && !b[22]);
        inf_a  = (ea == 255) && !nan_a;
        inf_b  = (eb == 255) && !nan_b;
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b) return {snan, 4'b0000, 32'h7FC00000};
        if ((inf_a && zero_b) || (zero_a && inf_b)) return {5'b10000, 32'h7FC00000};
        if (inf_a || inf_b) return {5'b00000, sign, 8'hFF, 23'h0};
        if (zero_a || zero_b) return {5'b00000, sign, 31'h0};
        p  = (longint'(1 << 23) + longint'(a[22:0])) * (longint'(1 << 23) + longint'(b[22:0]));
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = ea + eb - 127 + (sh - 23);
        if (e <= 0) return {5'b00011, sign, 31'h0};
        q       = p >> sh;
        rem     = p - (q << sh);
        half    = 64'd1 << (sh - 1);
        inexact = (rem != 0);
        case (mode)
            2'd0:    up = (rem > half) || ((rem == half) && q[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = inexact && !sign;
            default: up = inexact && sign;
        endcase
        if (up) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (mode == 2'd0) || (mode == 2'd2 && !sign) || (mode == 2'd3 && sign);
            return to_inf ? {5'b00101, sign, 8'hFF, 23'h0} : {5'b00101, sign, 8'hFE, 23'h7FFFFF};
        end
        return {4'b0000, inexact, sign, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        logic [7:0]  e;
        logic [22:0] f;
        int sel;
        sel = int'($urandom_range(0, 15));
        f   = 23'($urandom);
        case (sel)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = '0; end
            2:       begin e = 8'hFF; f[22] = 1'b1; end
            3:       begin e = 8'hFF; f[22] = 1'b0; f[0] = 1'b1; end
            4:       e = 8'($urandom_range(200, 254));
            5:       e = 8'($urandom_range(1, 60));
            default: e = 8'($urandom_range(100, 154));
        endcase
        v = {1'($urandom), e, f};
        return v;
    endfunction

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, input logic [3:0] t);
        op_t o;
        o.a = a; o.b = b; o.rm = m; o.tag = t;
        drv_q.push_back(o);
    endtask

    // One clock: drive at the falling edge, sample 1ns later, then cross the rising edge.
    task automatic step(input logic ordy);
        op_t o;
        logic [40:0] e;
        out_ready = ordy;
        if (drv_q.size() > 0) begin
            in_valid = 1'b1;
            op_a     = drv_q[0].a;
            op_b     = drv_q[0].b;
            rm       = drv_q[0].rm;
            in_tag   = drv_q[0].tag;
        end else begin
            in_valid = 1'b0;
        end
        #1;
        last_in_ready = in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 64'(result), 64'(e[31:0]));
                check("flags", 64'(flags), 64'(e[36:32]));
                check("tag", 64'(out_tag), 64'(e[40:37]));
                n_pop++;
                out_cyc = cyc;
            end
        end
        if (in_valid && in_ready) begin
            o = drv_q.pop_front();
            exp_q.push_back({o.tag, ref_mul(o.a, o.b, o.rm)});
            n_acc++;
            in_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        drv_q.delete();
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || drv_q.size() > 0) && guard < 3000) begin
            step(1'b1);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size() + drv_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, a0, guard;
        logic [31:0] held;
        @(negedge clk);
        do_reset();

        // Latency of an isolated op.
        push_op(32'h3FC00000, 32'h40000000, 2'd0, 4'd1);
        p0 = n_pop;
        guard = 0;
        while (n_pop == p0 && guard < 10) begin
            step(1'b1);
            guard++;
        end
        check("latency_seen", 64'(n_pop - p0), 64'd1);
        check("latency", 64'(out_cyc - in_cyc), 64'd3);

        // Directed corner vectors.
        push_op(32'h3F800001, 32'h3F800001, 2'd0, 4'd2);
        push_op(32'h3F800001, 32'h3F800001, 2'd2, 4'd3);
        push_op(32'h3F800001, 32'h3F800001, 2'd1, 4'd4);
        push_op(32'h7F000000, 32'h7F000000, 2'd0, 4'd5);
        push_op(32'h7F000000, 32'h7F000000, 2'd1, 4'd6);
        push_op(32'hFF000000, 32'h7F000000, 2'd2, 4'd7);
        push_op(32'h7F800000, 32'h00000000, 2'd0, 4'd8);
        push_op(32'h7F800001, 32'h3F800000, 2'd0, 4'd9);
        push_op(32'hFF800000, 32'h40000000, 2'd0, 4'd10);
        push_op(32'h00800000, 32'h3F000000, 2'd0, 4'd11);
        push_op(32'h00000001, 32'h7F000000, 2'd0, 4'd12);
        drain();

        // Backpressure: six tagged ops against a stalled consumer.
        for (int i = 0; i < 6; i++)
            push_op(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 4'(i));
        a0 = n_acc;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (i == 3) held = result;
        end
        check("bp_accepted", 64'(n_acc - a0), 64'd3);
        check("bp_in_ready", 64'(last_in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold", 64'(result), 64'(held));
        p0 = n_pop;
        drain();
        check("bp_pops", 64'(n_pop - p0), 64'd6);

        // Randomized stream with random consumer stalls.
        for (int i = 0; i < 300; i++)
            push_op(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 4'($urandom));
        guard = 0;
        while (drv_q.size() > 0 && guard < 3000) begin
            step(1'($urandom_range(0, 9) < 7));
            guard++;
        end
        drain();

        // Reset in the middle of a stream discards everything in flight.
        for (int i = 0; i < 5; i++)
            push_op(rand_op(), rand_op(), 2'd0, 4'(i));
        for (int i = 0; i < 4; i++) step(1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check("stale_out_valid", 64'(out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier: the successor to the single-cycle FP32 `multiplier`. It generalises exponent and mantissa width and adds four rounding modes, full special-value handling, IEEE exception flags, and a fixed 3-stage pipeline with valid/ready backpressure and tag passthrough. It sits between the FPU operand issue logic and the result writeback arbiter.

## Interface
- `EXP_W`, 8: exponent field width.
- `MAN_W`, 23: stored mantissa (fraction) width. Word width is `W = 1+EXP_W+MAN_W`.
- `TAG_W`, 4: sideband tag width, returned unchanged with the result.
- `clk` input 1: clock, rising edge. One clock domain.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block accepts the operand pair this cycle.
- `op_a`, `op_b` input W: IEEE operands.
- `rm` input 2: rounding mode. 0 = RNE, 1 = RTZ, 2 = RUP (toward +inf), 3 = RDN (toward -inf).
- `in_tag` input TAG_W: sideband tag.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output W: product.
- `flags` output 5: {nv, dz, of, uf, nx}. `dz` is always 0.
- `out_tag` output TAG_W: tag of the result.

## Operation
- **Classification, per operand:**
  - ZERO: exp=0. Subnormals are treated as zero (DAZ).
  - NORM.
  - INF: exp all ones, frac=0.
  - QNAN: exp all ones, frac MSB=1.
  - SNAN: exp all ones, frac MSB=0, frac≠0.
- **Sign:** `sa^sb` for every non-NaN result, including zero and inf.
- **Special cases** (evaluated in priority order; the first matching rule wins):
  1. Any NaN operand -> canonical qNaN (sign 0, exp all ones, frac = 1 followed by zeros). `nv` is set if either operand is SNAN.
  2. INF×ZERO -> canonical qNaN, `nv`.
  3. INF×anything else -> ±inf, no flags.
  4. ZERO×anything else -> ±0, no flags.
- **Normal path:**
  - Significands `{1,frac}` multiply into a `2*(MAN_W+1)`-bit product.
  - Biased exponent `e = ea+eb-BIAS`, computed signed in EXP_W+2 bits, where `BIAS = 2^(EXP_W-1)-1`.
  - If the product MSB is set: shift right 1 and `e+1`.
  - Keep MAN_W fraction bits, plus guard, round, and a sticky (OR of all remaining bits).
- **Rounding:**
  - RNE: increment if G & (R|S|LSB).
  - RTZ: never increment.
  - RUP: increment if (G|R|S) & !sign.
  - RDN: increment if (G|R|S) & sign.
  - `nx` = G|R|S.
  - A carry out of the mantissa renormalises the result (fraction becomes 0, `e+1`).
- **Overflow** (`e ≥ 2^EXP_W-1` after rounding): sets `of` and `nx`.
  - Result is ±inf for RNE, for RUP with positive sign, and for RDN with negative sign.
  - Otherwise the result is ±max finite (exp = all ones−1, frac all ones).
- **Underflow** (`e ≤ 0` after normalisation, before rounding): flush to signed zero (FTZ). Sets `uf` and `nx` regardless of rounding mode.

## Timing
- **Stages:**
  - S1: classify, sign, exponent sum, register.
  - S2: significand product, register.
  - S3: normalise, round, pack, register. The S3 registers are the output registers.
- **Latency:** 3 cycles from an accepted input (`in_valid & in_ready`) to `out_valid`. Throughput is one result per cycle when `out_ready` is held high.
- **Advance and stall:**
  - Global advance enable `adv = !out_valid | out_ready`. All stages, including valid bits, move only when `adv=1`.
  - `in_ready = adv`, combinational.
  - Bubbles are not collapsed. While stalled, `in_ready=0` even if earlier stages are empty.
- **Output stability:** while `out_valid & !out_ready`, `result`, `flags` and `out_tag` hold stable.
- **Ordering:** `rm` and `in_tag` are captured with the operands. Results emerge in strict input order.
- **Reset:**
  - All stage valid bits, `out_valid`, `result`, `flags` and `out_tag` clear to 0 on the cycle `rst` is sampled high.
  - `in_ready` is 1 out of reset.
  - Reset mid-operation discards every in-flight operation with no output.
- **Simultaneous events:** a pop (`out_ready`) and a new accept in the same cycle are both legal. The pipeline shifts by one.

## Structure
- **Package `fp_mult_pkg`:**
  - Rounding-mode localparams (RM_RNE, RM_RTZ, RM_RUP, RM_RDN).
  - Flag bit indices (FLG_NV, FLG_DZ, FLG_OF, FLG_UF, FLG_NX).
  - Operand class enum (ZERO, NORM, INF, QNAN, SNAN).
  - Canonical-NaN constant function of EXP_W/MAN_W.
- **Sub-module `fp_mult_round`:** combinational S3 datapath (normalise, G/R/S, round increment, overflow/underflow select, pack), parametrised on EXP_W/MAN_W.
- **Top level:** pipeline registers, handshake, S1/S2 logic.

## Test plan
All values are FP32 defaults.
- **Basic product:** 0x3FC00000 × 0x40000000, RNE -> 0x40400000, flags 0; `out_valid` exactly 3 cycles after accept.
- **Rounding modes:** 0x3F800001 × 0x3F800001 -> RNE 0x3F800002, nx; RUP 0x3F800003, nx; RTZ 0x3F800002, nx.
- **Overflow:** 0x7F000000 × 0x7F000000 -> RNE 0x7F800000, of+nx; RTZ 0x7F7FFFFF, of+nx. 0xFF000000 × 0x7F000000 RUP -> 0xFF7FFFFF.
- **Specials:**
  - 0x7F800000 × 0x00000000 -> 0x7FC00000, nv.
  - 0x7F800001 × 0x3F800000 -> 0x7FC00000, nv.
  - 0xFF800000 × 0x40000000 -> 0xFF800000, flags 0.
- **Underflow:** 0x00800000 × 0x3F000000 -> 0x00000000, uf+nx. Subnormal input 0x00000001 × 0x7F000000 -> 0x00000000, flags 0.
- **Backpressure and reset:**
  - Stream 6 tagged ops (tags 0..5) with `out_ready` low for 5 cycles. `in_ready` drops once 3 are in flight; no result is lost or duplicated; tags emerge in order 0..5.
  - Assert `rst` mid-stream -> `out_valid`=0 the next cycle and no stale outputs afterwards.
